uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver paired with the existing UART transmitter; it deserialises an asynchronous 8N1 line into bytes. It uses the shared baud-tick generator at OVS× the baud rate and detects the start bit at mid-bit. Received bytes go into a one-entry holding register with a valid/ack handshake toward the consumer. Framing errors and overruns are flagged.

Parameters:
DBIT, 8, data bits per frame, LSB first
OVS, 16, s_tick pulses per bit period; even, ≥4
SB_TICK, 16, s_tick pulses counted in the stop state; OVS gives 1 stop bit

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-low reset
s_tick  input  1  one-clock strobe, OVS per bit period
rx  input  1  serial line, idle high, asynchronous to clock
rx_ack  input  1  consumer has taken data_out; clears rx_valid
data_out  output  DBIT  last good received byte, held until replaced
rx_valid  output  1  data_out holds an unacknowledged byte
rx_done  output  1  one-clock pulse when a byte is stored into data_out
frame_err  output  1  one-clock pulse when the stop bit samples low
overrun  output  1  one-clock pulse when a good byte is dropped because rx_valid is set
busy  output  1  receiver state ≠ IDLE

Behaviour:
- Reset (reset=0 at a clock edge):
  - State = IDLE; tick/bit counters and shift register = 0.
  - Both synchroniser flops = 1.
  - data_out = 0; rx_valid, rx_done, frame_err, overrun and busy = 0.
  - Reset mid-frame abandons the frame with no flags.
- rx passes through a 2-flop synchroniser (rx_s); rx_s lags rx by 2 clocks. Only rx_s is used.
- All counters advance only on clocks where s_tick=1. Without s_tick, state and counters hold.
- tick_cnt width is clog2(max(OVS,SB_TICK)); bit_cnt width is clog2(DBIT).
- IDLE: when rx_s=0 (no s_tick needed), go to START with tick_cnt=0.
- START: on each s_tick:
  - If tick_cnt = OVS/2−1 and rx_s=0: go to DATA; tick_cnt=0; bit_cnt=0.
  - If tick_cnt = OVS/2−1 and rx_s=1: treat as a glitch; go to IDLE with no flags.
  - Otherwise increment tick_cnt.
- DATA: on each s_tick:
  - If tick_cnt = OVS−1: tick_cnt=0; shift rx_s in at the MSB and shift right, so the first bit ends at the LSB.
  - After that shift, go to STOP if bit_cnt = DBIT−1, otherwise increment bit_cnt.
  - Otherwise increment tick_cnt.
- STOP: on each s_tick:
  - If tick_cnt = SB_TICK−1: sample rx_s and go to IDLE. The receiver re-arms at mid stop bit.
  - Otherwise increment tick_cnt.
- Completion, registered and visible the clock after the sampling edge:
  - Stop bit = 0: frame_err pulses; the byte is discarded; data_out and rx_valid are unchanged.
  - Stop bit = 1 and rx_valid=0: data_out = shift register; rx_valid=1; rx_done pulses.
  - Stop bit = 1, rx_valid=1 and no rx_ack that clock: the new byte is dropped; data_out keeps the old byte; overrun pulses; rx_done stays low.
  - Stop bit = 1, rx_valid=1 and rx_ack in the same clock: the ack wins first, then the new byte loads. rx_valid stays 1, rx_done pulses and overrun stays 0.
- rx_ack with no completion: rx_valid=0 next clock. rx_ack while rx_valid=0 is ignored.
- Pulse outputs are high for exactly one clock. At most one of rx_done, frame_err and overrun is high in any clock.
- Line held low (break): START→DATA→STOP, then frame_err. The receiver then re-enters START from IDLE and keeps reporting frame_err once per frame time.

Test Plan:
1. Defaults, s_tick every 4 clocks, rx_ack=0; send 0xA5 at 64 clocks/bit -> one rx_done pulse, data_out=0xA5, rx_valid=1, frame_err=0, overrun=0; busy falls at mid stop bit.
2. rx low for 3 ticks (12 clocks), then high -> START is aborted at tick 7; busy returns to 0; no rx_done or frame_err; data_out unchanged.
3. Send 0x3C with stop bit forced 0 -> frame_err pulses for exactly 1 clock; rx_valid=0; data_out keeps its previous value (0x00 after reset).
4. Send 0x11 then 0x22 with no rx_ack -> rx_done after 0x11, then overrun after 0x22; data_out=0x11 and rx_valid=1 throughout. Then pulse rx_ack -> rx_valid=0 on the next clock.
5. Send 0x11, then 0x22 with rx_ack asserted exactly in 0x22's completion clock -> data_out=0x22, rx_valid=1, rx_done pulses, overrun=0.
6. Assert reset=0 for 1 clock during DATA bit 3 -> all outputs return to reset values with busy=0 and no flags. Then a full 0x5A frame -> data_out=0x5A, rx_done pulses once.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchroniser, oversampled mid-bit sampling,
// one-entry holding register with valid/ack handshake, framing/overrun pulses.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rx_ack,
  output logic [DBIT-1:0] data_out,
  output logic            rx_valid,
  output logic            rx_done,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
);

  localparam int TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_BIT  = TW'(OVS - 1);
  localparam logic [TW-1:0] TICK_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_tick,  w_tick_nxt;
  logic [BW-1:0]   r_bit,   w_bit_nxt;
  logic [DBIT-1:0] r_shift, w_shift_nxt;
  logic            r_sync1, r_sync2;
  logic            w_sample;

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_sample    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = S_START;
          w_tick_nxt  = '0;
        end
      end
      S_START: begin
        if (s_tick) begin
          if (r_tick == TICK_MID) begin
            // A line that is high again at mid start bit was only a glitch.
            w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (r_tick == TICK_BIT) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {r_sync2, r_shift[DBIT-1:1]};
            if (r_bit == BIT_LAST) w_state_nxt = S_STOP;
            else                   w_bit_nxt   = r_bit + 1'b1;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (s_tick) begin
          if (r_tick == TICK_STOP) begin
            w_sample    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Holding register: an ack in the completion clock frees the slot for the new byte.
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_out  <= '0;
      rx_valid  <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_ack) rx_valid <= 1'b0;
      if (w_sample) begin
        if (!r_sync2) begin
          frame_err <= 1'b1;
        end else if (!rx_valid || rx_ack) begin
          data_out <= r_shift;
          rx_valid <= 1'b1;
          rx_done  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected completion events are queued at stimulus
// time and a negedge monitor pops and compares them as the DUT pulses.
module tb_uart_rx;

  localparam int CLK_PER_BIT = 64;

  logic       clock = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic       rx_ack;
  logic [7:0] data_out;
  logic       rx_valid, rx_done, frame_err, overrun, busy;

  uart_rx #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .s_tick   (s_tick),
    .rx       (rx),
    .rx_ack   (rx_ack),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // s_tick high for one clock in every four.
  logic [1:0] tdiv = 2'd0;
  initial s_tick = 1'b0;
  always @(posedge clock) begin
    #1;
    tdiv   = tdiv + 2'd1;
    s_tick = (tdiv == 2'd0);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected event: flags = {rx_done, frame_err, overrun}.
  typedef struct {
    logic [2:0] flags;
    logic [7:0] data;
    logic       valid;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;

  logic [2:0] prev_flags = 3'b000;
  always @(negedge clock) begin
    logic [2:0] cur;
    ev_t        e;
    cur = {rx_done, frame_err, overrun};
    if (|(cur & prev_flags)) check("pulse_width", {29'd0, cur & prev_flags}, 32'd0);
    if (cur != 3'b000) begin
      check("pulse_exclusive", $countones(cur), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_event", {29'd0, cur}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("event_kind", {29'd0, cur}, {29'd0, e.flags});
        check("event_data", {24'd0, data_out}, {24'd0, e.data});
        check("event_valid", {31'd0, rx_valid}, {31'd0, e.valid});
      end
    end
    prev_flags = cur;
  end

  // Queue the expected outcome of a frame from the bench's own holding-register model.
  task automatic predict(input logic [7:0] b, input logic stop, input bit ack_at_done);
    ev_t e;
    if (!stop) begin
      e.flags = 3'b010;
    end else if (!exp_valid || ack_at_done) begin
      e.flags   = 3'b100;
      exp_data  = b;
      exp_valid = 1'b1;
    end else begin
      e.flags = 3'b001;
    end
    e.data  = exp_data;
    e.valid = exp_valid;
    sb.push_back(e);
  endtask

  // Completion comes on the 152nd s_tick seen from the 4th edge after the start
  // bit is driven: 2 synchroniser clocks + 1 IDLE clock, then 8 + 8*16 + 16 ticks.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit ack_at_done);
    predict(b, stop, ack_at_done);
    fork
      begin
        rx = 1'b0;
        repeat (CLK_PER_BIT) @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
          rx = b[i];
          repeat (CLK_PER_BIT) @(posedge clock);
          #1;
        end
        rx = stop;
        if (stop) begin
          repeat (CLK_PER_BIT) @(posedge clock);
          #1;
        end else begin
          repeat (40) @(posedge clock);
          #1;
          rx = 1'b1;
          repeat (CLK_PER_BIT - 40) @(posedge clock);
          #1;
        end
        rx = 1'b1;
      end
      begin
        int e_cnt = 0;
        int n_tk  = 0;
        while (n_tk < 151 && e_cnt < 2000) begin
          @(posedge clock);
          e_cnt++;
          if (e_cnt >= 4 && s_tick) n_tk++;
        end
        if (n_tk < 151) begin
          check("tick_budget", n_tk, 151);
        end else begin
          repeat (3) @(posedge clock);
          #1;
          if (ack_at_done) rx_ack = 1'b1;
          @(negedge clock);
          check("busy_before_stop_sample", {31'd0, busy}, 32'd1);
          if (ack_at_done) check("valid_before_ack", {31'd0, rx_valid}, 32'd1);
          @(posedge clock);
          #1;
          rx_ack = 1'b0;
          @(negedge clock);
          check("busy_after_stop_sample", {31'd0, busy}, 32'd0);
        end
      end
    join
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(posedge clock);
    #1;
    rx_ack    = 1'b0;
    exp_valid = 1'b0;
    @(negedge clock);
    check("ack_clears_valid", {31'd0, rx_valid}, 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] d, input logic v, input logic bz);
    @(negedge clock);
    check({tag, "_data"}, {24'd0, data_out}, {24'd0, d});
    check({tag, "_valid"}, {31'd0, rx_valid}, {31'd0, v});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, bz});
    check({tag, "_flags"}, {29'd0, rx_done, frame_err, overrun}, 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_outputs("reset", 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (20) @(posedge clock);
    #1;

    // 1: clean frame 0xA5.
    send_frame(8'hA5, 1'b1, 1'b0);
    check_outputs("t1", 8'hA5, 1'b1, 1'b0);
    ack_pulse();

    // 2: 12-clock low glitch aborts at mid start bit.
    rx = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    rx = 1'b1;
    @(negedge clock);
    check("t2_busy_in_start", {31'd0, busy}, 32'd1);
    repeat (60) @(posedge clock);
    #1;
    check_outputs("t2", 8'hA5, 1'b0, 1'b0);

    // 3: from reset, a frame with a low stop bit.
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset     = 1'b1;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    check_outputs("t3_reset", 8'h00, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (60) @(posedge clock);
    #1;
    check_outputs("t3", 8'h00, 1'b0, 1'b0);

    // 4: two bytes without ack -> second overruns.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check_outputs("t4", 8'h11, 1'b1, 1'b0);
    ack_pulse();

    // 5: ack in the completion clock lets the second byte load.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    check_outputs("t5", 8'h22, 1'b1, 1'b0);

    // 6: reset during data bit 3, then a full 0x5A frame.
    rx = 1'b0;
    repeat (CLK_PER_BIT) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1 || i == 2) ? 1'b1 : 1'b0;
      repeat (CLK_PER_BIT) @(posedge clock);
      #1;
    end
    rx = 1'b1;
    repeat (CLK_PER_BIT / 2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset     = 1'b1;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    check_outputs("t6_reset", 8'h00, 1'b0, 1'b0);
    repeat (700) @(posedge clock);
    #1;
    check_outputs("t6_idle", 8'h00, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    check_outputs("t6", 8'h5A, 1'b1, 1'b0);

    repeat (20) @(posedge clock);
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
